// File: rtl/gpu_fill_rasterizer.sv
// rtl/gpu_fill_rasterizer.sv - rectangle fill engine walking clipped pixels in raster order
module gpu_fill_rasterizer #(
    parameter int WIDTH_BITS  = 10,
    parameter int HEIGHT_BITS = 9,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [WIDTH_BITS-1:0]  x0_i,
    input  logic [WIDTH_BITS-1:0]  x1_i,
    input  logic [HEIGHT_BITS-1:0] y0_i,
    input  logic [HEIGHT_BITS-1:0] y1_i,
    input  logic                   stall_i,
    output logic [WIDTH_BITS-1:0]  x_fill_o,
    output logic [HEIGHT_BITS-1:0] y_fill_o,
    output logic                   fill_active_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam logic [WIDTH_BITS-1:0]  X_LAST = WIDTH_BITS'(SCREEN_W - 1);
    localparam logic [HEIGHT_BITS-1:0] Y_LAST = HEIGHT_BITS'(SCREEN_H - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

    state_t state, state_nx;

    logic [WIDTH_BITS-1:0]  cx0, cx1, xmin, xmax;
    logic [HEIGHT_BITS-1:0] cy0, cy1, ymin, ymax;
    logic [WIDTH_BITS-1:0]  sx_lo, sx_hi;
    logic [HEIGHT_BITS-1:0] sy_lo, sy_hi;
    logic                   empty_rect;
    logic                   accept;
    logic                   at_x_end, at_y_end;

    // Ordered and clipped bounds from the captured corners, used only in SETUP.
    always_comb begin
        sx_lo = (cx0 < cx1) ? cx0 : cx1;
        sx_hi = (cx0 < cx1) ? cx1 : cx0;
        sy_lo = (cy0 < cy1) ? cy0 : cy1;
        sy_hi = (cy0 < cy1) ? cy1 : cy0;
        if (sx_hi > X_LAST) sx_hi = X_LAST;
        if (sy_hi > Y_LAST) sy_hi = Y_LAST;
        empty_rect = (sx_lo > X_LAST) || (sy_lo > Y_LAST);
    end

    assign accept   = (state == SCAN) && !stall_i && !abort_i;
    assign at_x_end = (x_fill_o == xmax);
    assign at_y_end = (y_fill_o == ymax);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start_i) state_nx = SETUP;
            SETUP: begin
                if (abort_i)         state_nx = IDLE;
                else if (empty_rect) state_nx = DONE;
                else                 state_nx = SCAN;
            end
            SCAN: begin
                if (abort_i)                          state_nx = IDLE;
                else if (accept && at_x_end && at_y_end) state_nx = DONE;
            end
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        fill_active_o = (state == SCAN);
        busy_o        = (state == SETUP) || (state == SCAN);
        done_o        = (state == DONE);
    end

    // Compare-before-increment keeps x/y inside the clipped bounds at all times.
    always_ff @(posedge clk) begin
        if (rst) begin
            cx0      <= '0;
            cx1      <= '0;
            cy0      <= '0;
            cy1      <= '0;
            xmin     <= '0;
            xmax     <= '0;
            ymin     <= '0;
            ymax     <= '0;
            x_fill_o <= '0;
            y_fill_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        cx0 <= x0_i;
                        cx1 <= x1_i;
                        cy0 <= y0_i;
                        cy1 <= y1_i;
                    end
                end
                SETUP: begin
                    if (!abort_i && !empty_rect) begin
                        xmin     <= sx_lo;
                        xmax     <= sx_hi;
                        ymin     <= sy_lo;
                        ymax     <= sy_hi;
                        x_fill_o <= sx_lo;
                        y_fill_o <= sy_lo;
                    end
                end
                SCAN: begin
                    if (accept) begin
                        if (!at_x_end) begin
                            x_fill_o <= x_fill_o + 1'b1;
                        end else if (!at_y_end) begin
                            x_fill_o <= xmin;
                            y_fill_o <= y_fill_o + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_fill_rasterizer.sv
// tb/tb_gpu_fill_rasterizer.sv - randomized bench against a pixel-list reference model
module tb_gpu_fill_rasterizer;

    logic       clk = 0;
    logic       rst = 1;
    logic       start_i = 0;
    logic       abort_i = 0;
    logic [9:0] x0_i = 0, x1_i = 0;
    logic [8:0] y0_i = 0, y1_i = 0;
    logic       stall_i = 0;
    logic [9:0] x_fill_o;
    logic [8:0] y_fill_o;
    logic       fill_active_o, busy_o, done_o;

    int check_count = 0;
    int fail_count  = 0;

    gpu_fill_rasterizer #(.WIDTH_BITS(10), .HEIGHT_BITS(9), .SCREEN_W(640), .SCREEN_H(480)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .x0_i(x0_i), .x1_i(x1_i), .y0_i(y0_i), .y1_i(y1_i), .stall_i(stall_i),
        .x_fill_o(x_fill_o), .y_fill_o(y_fill_o), .fill_active_o(fill_active_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        check_count++;
        if (got != exp) begin
            fail_count++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // kill_at: accepted-pixel index at which abort (or rst) is raised, -1 for none.
    task automatic run_fill(input int ax0, input int ax1, input int ay0, input int ay1,
                            input int stall_pct, input int st_at, input int st_len,
                            input int kill_at, input bit use_rst);
        int qx[$];
        int qy[$];
        int lo_x, hi_x, lo_y, hi_y, n_pix, acc, stalls, held, rel;
        bit s, done_seen, killed, stop, any_done;
        lo_x = (ax0 < ax1) ? ax0 : ax1;
        hi_x = (ax0 < ax1) ? ax1 : ax0;
        lo_y = (ay0 < ay1) ? ay0 : ay1;
        hi_y = (ay0 < ay1) ? ay1 : ay0;
        if (hi_x > 639) hi_x = 639;
        if (hi_y > 479) hi_y = 479;
        if (lo_x <= 639 && lo_y <= 479)
            for (int yy = lo_y; yy <= hi_y; yy++)
                for (int xx = lo_x; xx <= hi_x; xx++) begin
                    qx.push_back(xx);
                    qy.push_back(yy);
                end
        n_pix = qx.size();

        @(negedge clk);
        x0_i = 10'(ax0); x1_i = 10'(ax1); y0_i = 9'(ay0); y1_i = 9'(ay1);
        start_i = 1;
        @(negedge clk);
        start_i = 0;
        chk("setup_busy", int'(busy_o), 1);
        chk("setup_active", int'(fill_active_o), 0);

        acc = 0; stalls = 0; held = 0;
        done_seen = 0; killed = 0; stop = 0;
        for (rel = 2; rel < 4000 && !done_seen && !killed && !stop; rel++) begin
            @(negedge clk);
            stall_i = 0;
            if (done_o) begin
                done_seen = 1;
                chk("done_time", rel, 2 + n_pix + stalls);
                chk("pix_count", acc, n_pix);
                chk("done_active", int'(fill_active_o), 0);
                chk("done_busy", int'(busy_o), 0);
            end else if (fill_active_o) begin
                if (qx.size() == 0) begin
                    chk("extra_pixel", int'(fill_active_o), 0);
                    stop = 1;
                end else begin
                    chk("px_x", int'(x_fill_o), qx[0]);
                    chk("px_y", int'(y_fill_o), qy[0]);
                    chk("scan_busy", int'(busy_o), 1);
                    if (acc == kill_at) begin
                        killed = 1;
                        stall_i = 1'($urandom_range(0, 1));
                        if (use_rst) rst = 1;
                        else         abort_i = 1;
                    end else begin
                        if (acc == st_at && held < st_len) begin
                            s = 1;
                            held++;
                        end else begin
                            s = ($urandom_range(0, 99) < stall_pct);
                        end
                        stall_i = s;
                        if (s) stalls++;
                        else begin
                            void'(qx.pop_front());
                            void'(qy.pop_front());
                            acc++;
                        end
                    end
                end
            end else begin
                chk("lost_active", int'(fill_active_o), 1);
                stop = 1;
            end
        end

        if (done_seen) begin
            @(negedge clk);
            chk("done_pulse_width", int'(done_o), 0);
            chk("back_idle", int'(busy_o), 0);
        end else if (killed) begin
            @(negedge clk);
            rst = 0; abort_i = 0; stall_i = 0;
            chk("kill_active", int'(fill_active_o), 0);
            chk("kill_busy", int'(busy_o), 0);
            chk("kill_done", int'(done_o), 0);
            if (use_rst) begin
                chk("rst_x", int'(x_fill_o), 0);
                chk("rst_y", int'(y_fill_o), 0);
            end
            any_done = 0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                any_done |= done_o;
            end
            chk("kill_no_done", int'(any_done), 0);
        end else if (!stop) begin
            chk("timeout", int'(done_seen), 1);
        end
        stall_i = 0;
    endtask

    initial begin
        int bx, by, ex, ey, t;
        @(negedge clk);
        chk("rst_active", int'(fill_active_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_x0", int'(x_fill_o), 0);
        chk("rst_y0", int'(y_fill_o), 0);
        @(negedge clk);
        rst = 0;

        run_fill(1, 2, 1, 2, 0, -1, 0, -1, 0);          // basic 2x2
        run_fill(5, 3, 3, 3, 0, -1, 0, -1, 0);          // swapped corners
        run_fill(0, 3, 0, 0, 0, 1, 3, -1, 0);           // held pixel (1,0)
        run_fill(630, 700, 470, 500, 0, -1, 0, -1, 0);  // clipped to 100 pixels
        run_fill(650, 700, 10, 20, 0, -1, 0, -1, 0);    // fully offscreen
        run_fill(7, 7, 9, 9, 0, -1, 0, -1, 0);          // single pixel
        run_fill(10, 13, 4, 5, 0, -1, 0, 2, 0);         // abort at 3rd pixel
        run_fill(2, 4, 2, 3, 0, -1, 0, -1, 0);
        run_fill(10, 13, 4, 5, 0, -1, 0, 2, 1);         // reset at 3rd pixel
        run_fill(2, 4, 2, 3, 0, -1, 0, -1, 0);

        for (int n = 0; n < 30; n++) begin
            bx = ($urandom_range(0, 3) == 0) ? $urandom_range(620, 700) : $urandom_range(0, 639);
            by = ($urandom_range(0, 3) == 0) ? $urandom_range(465, 500) : $urandom_range(0, 479);
            ex = bx + $urandom_range(0, 7);
            ey = by + $urandom_range(0, 5);
            if (ex > 1023) ex = 1023;
            if (ey > 511)  ey = 511;
            if ($urandom_range(0, 1) == 1) begin t = bx; bx = ex; ex = t; end
            if ($urandom_range(0, 1) == 1) begin t = by; by = ey; ey = t; end
            run_fill(bx, ex, by, ey, 30, -1, 0,
                     ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : -1,
                     1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
